// File: rtl/iob_fifo_sync_asym_pkg.sv
// Shared helpers for the asymmetric synchronous FIFO controller: width math
// reused by the controller, its port interface and the external RAM.
package iob_fifo_sync_asym_pkg;

  function automatic int iob_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int iob_min(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  // Number of minimum-width units packed into one word of data_w bits.
  function automatic int word_incr(input int data_w, input int w_data_w, input int r_data_w);
    return data_w / iob_min(w_data_w, r_data_w);
  endfunction

  // RAM port address width: unit address minus the lane-select bits.
  function automatic int port_addr_w(input int data_w, input int w_data_w,
                                     input int r_data_w, input int addr_w);
    return addr_w - $clog2(word_incr(data_w, w_data_w, r_data_w));
  endfunction

  typedef enum logic [1:0] {
    LVL_HOLD = 2'd0,
    LVL_PUSH = 2'd1,
    LVL_POP  = 2'd2,
    LVL_BOTH = 2'd3
  } lvl_op_e;

endpackage

// File: rtl/iob_fifo_sync_asym_if.sv
// Producer/consumer and external-RAM signals of the asymmetric FIFO controller.
// The controller takes the slave side; the surrounding logic and RAM the master side.
interface iob_fifo_sync_asym_if
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
);

  localparam int W_ADDR_W = port_addr_w(W_DATA_W, W_DATA_W, R_DATA_W, ADDR_W);
  localparam int R_ADDR_W = port_addr_w(R_DATA_W, W_DATA_W, R_DATA_W, ADDR_W);

  logic                w_en;
  logic [W_DATA_W-1:0] w_data;
  logic                w_full;
  logic                r_en;
  logic [R_DATA_W-1:0] r_data;
  logic                r_empty;
  logic [ADDR_W:0]     level;

  logic                ext_mem_w_en;
  logic [W_ADDR_W-1:0] ext_mem_w_addr;
  logic [W_DATA_W-1:0] ext_mem_w_data;
  logic                ext_mem_r_en;
  logic [R_ADDR_W-1:0] ext_mem_r_addr;
  logic [R_DATA_W-1:0] ext_mem_r_data;

  modport slave (
    input  w_en, w_data, r_en, ext_mem_r_data,
    output w_full, r_data, r_empty, level,
    output ext_mem_w_en, ext_mem_w_addr, ext_mem_w_data,
    output ext_mem_r_en, ext_mem_r_addr
  );

  modport master (
    output w_en, w_data, r_en, ext_mem_r_data,
    input  w_full, r_data, r_empty, level,
    input  ext_mem_w_en, ext_mem_w_addr, ext_mem_w_data,
    input  ext_mem_r_en, ext_mem_r_addr
  );

endinterface

// File: rtl/iob_fifo_sync_asym_counter_step.sv
// Wrapping counter that advances by a constant step when enabled.
// Used for the write and read pointers of the asymmetric FIFO.
module iob_counter_step #(
  parameter int W    = 4,
  parameter int STEP = 1
) (
  input  logic         clk,
  input  logic         arst_n,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  localparam logic [W-1:0] STEP_L = W'(STEP);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Overflow wraps silently; occupancy is tracked elsewhere.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) begin
      cnt_d = cnt_q + STEP_L;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/iob_fifo_sync_asym.sv
// Single-clock FIFO controller with independent write/read widths driving an
// external asymmetric two-port RAM; owns pointers, level and full/empty flags.
module iob_fifo_sync_asym
  import iob_fifo_sync_asym_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  arst_n,
  iob_fifo_sync_asym_if.slave   bus
);

  localparam int MINDATA_W = iob_min(W_DATA_W, R_DATA_W);
  localparam int W_INCR    = W_DATA_W / MINDATA_W;
  localparam int R_INCR    = R_DATA_W / MINDATA_W;
  localparam int W_LSB     = $clog2(W_INCR);
  localparam int R_LSB     = $clog2(R_INCR);
  localparam int CAPACITY  = 2 ** ADDR_W;

  localparam logic [ADDR_W:0] W_STEP_L  = (ADDR_W + 1)'(W_INCR);
  localparam logic [ADDR_W:0] R_STEP_L  = (ADDR_W + 1)'(R_INCR);
  localparam logic [ADDR_W:0] FULL_THR  = (ADDR_W + 1)'(CAPACITY - W_INCR);

  logic [ADDR_W-1:0] w_ptr;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W:0]   level_q;
  logic [ADDR_W:0]   level_d;
  logic              w_full;
  logic              r_empty;
  logic              w_acc;
  logic              r_acc;
  lvl_op_e           lvl_op;

  // Flags depend only on the registered level, so a same-cycle write never
  // rescues a read from empty (and vice versa).
  assign w_full  = level_q > FULL_THR;
  assign r_empty = level_q < R_STEP_L;
  assign w_acc   = bus.w_en & ~w_full;
  assign r_acc   = bus.r_en & ~r_empty;

  iob_counter_step #(
    .W    (ADDR_W),
    .STEP (W_INCR)
  ) u_w_ptr (
    .clk    (clk),
    .arst_n (arst_n),
    .en_i   (w_acc),
    .cnt_o  (w_ptr)
  );

  iob_counter_step #(
    .W    (ADDR_W),
    .STEP (R_INCR)
  ) u_r_ptr (
    .clk    (clk),
    .arst_n (arst_n),
    .en_i   (r_acc),
    .cnt_o  (r_ptr)
  );

  always_comb begin
    lvl_op = LVL_HOLD;
    if (w_acc && r_acc) begin
      lvl_op = LVL_BOTH;
    end else if (w_acc) begin
      lvl_op = LVL_PUSH;
    end else if (r_acc) begin
      lvl_op = LVL_POP;
    end
  end

  always_comb begin
    level_d = level_q;
    unique case (lvl_op)
      LVL_PUSH: level_d = level_q + W_STEP_L;
      LVL_POP:  level_d = level_q - R_STEP_L;
      LVL_BOTH: level_d = level_q + W_STEP_L - R_STEP_L;
      default:  level_d = level_q;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      level_q <= '0;
    end else begin
      level_q <= level_d;
    end
  end

  // Unit pointers drop their lane-select bits to form RAM word addresses.
  assign bus.ext_mem_w_en   = w_acc;
  assign bus.ext_mem_w_addr = w_ptr[ADDR_W-1:W_LSB];
  assign bus.ext_mem_w_data = bus.w_data;
  assign bus.ext_mem_r_en   = r_acc;
  assign bus.ext_mem_r_addr = r_ptr[ADDR_W-1:R_LSB];

  assign bus.r_data  = bus.ext_mem_r_data;
  assign bus.w_full  = w_full;
  assign bus.r_empty = r_empty;
  assign bus.level   = level_q;

endmodule

// File: tb/tb_iob_fifo_sync_asym.sv
// Scoreboard bench for iob_fifo_sync_asym (32-bit write, 8-bit read, 16 bytes)
// with a behavioural asymmetric RAM attached to the ext_mem ports.
module tb_iob_fifo_sync_asym;

  localparam int W_DATA_W = 32;
  localparam int R_DATA_W = 8;
  localparam int ADDR_W   = 4;
  localparam int MIN_W    = 8;
  localparam int W_INCR   = 4;
  localparam int R_INCR   = 1;
  localparam int CAP      = 16;

  logic clk = 1'b0;
  logic arst_n;

  always #5 clk = ~clk;

  iob_fifo_sync_asym_if #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) bus ();

  iob_fifo_sync_asym #(
    .W_DATA_W (W_DATA_W),
    .R_DATA_W (R_DATA_W),
    .ADDR_W   (ADDR_W)
  ) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .bus    (bus)
  );

  // Behavioural asymmetric RAM: low write lane lands at the lowest unit address.
  logic [MIN_W-1:0] mem [CAP];

  always_ff @(posedge clk) begin
    if (bus.ext_mem_w_en) begin
      for (int k = 0; k < W_INCR; k++) begin
        mem[int'(bus.ext_mem_w_addr) * W_INCR + k] <= bus.ext_mem_w_data[k*MIN_W +: MIN_W];
      end
    end
    if (bus.ext_mem_r_en) begin
      bus.ext_mem_r_data <= mem[int'(bus.ext_mem_r_addr) * R_INCR];
    end
  end

  int         nChecks = 0;
  int         nPass   = 0;
  int         expLevel = 0;
  logic [7:0] sb [$];
  logic [7:0] lastRead = 8'h00;

  // One clock of stimulus with acceptance predicted from the bench's own level.
  task automatic applyStimulus(input logic we, input logic [31:0] wd, input logic re);
    logic       wAcc;
    logic       rAcc;
    logic [7:0] expByte;
    @(negedge clk);
    bus.w_en   = we;
    bus.w_data = wd;
    bus.r_en   = re;
    wAcc = we && (expLevel <= CAP - W_INCR);
    rAcc = re && (expLevel >= R_INCR);
    #1;
    nChecks++;
    if (bus.ext_mem_w_en !== wAcc) $display("[TB] FAIL ext_mem_w_en: got %b want %b", bus.ext_mem_w_en, wAcc);
    else nPass++;
    nChecks++;
    if (bus.ext_mem_r_en !== rAcc) $display("[TB] FAIL ext_mem_r_en: got %b want %b", bus.ext_mem_r_en, rAcc);
    else nPass++;
    expByte = 8'h00;
    if (rAcc) expByte = sb.pop_front();
    if (wAcc) for (int k = 0; k < W_INCR; k++) sb.push_back(wd[k*8 +: 8]);
    @(posedge clk);
    #1;
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    expLevel = expLevel + (wAcc ? W_INCR : 0) - (rAcc ? R_INCR : 0);
    nChecks++;
    if (bus.level !== 5'(expLevel)) $display("[TB] FAIL level: got %0d want %0d", bus.level, expLevel);
    else nPass++;
    if (rAcc) begin
      nChecks++;
      if (bus.r_data !== expByte) $display("[TB] FAIL r_data: got %h want %h", bus.r_data, expByte);
      else nPass++;
      lastRead = expByte;
    end
  endtask

  task automatic applyReset();
    @(negedge clk);
    #2 arst_n = 1'b0;
    #2 arst_n = 1'b1;
    expLevel = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    bus.w_en   = 1'b0;
    bus.r_en   = 1'b0;
    bus.w_data = '0;
    arst_n     = 1'b0;
    #3;
    nChecks++;
    if (bus.level !== 5'd0) $display("[TB] FAIL reset level: got %0d want 0", bus.level); else nPass++;
    nChecks++;
    if (bus.r_empty !== 1'b1) $display("[TB] FAIL reset r_empty: got %b want 1", bus.r_empty); else nPass++;
    nChecks++;
    if (bus.w_full !== 1'b0) $display("[TB] FAIL reset w_full: got %b want 0", bus.w_full); else nPass++;
    nChecks++;
    if ({bus.ext_mem_w_en, bus.ext_mem_r_en} !== 2'b00)
      $display("[TB] FAIL reset ext enables: got %b want 00", {bus.ext_mem_w_en, bus.ext_mem_r_en});
    else nPass++;
    @(negedge clk);
    arst_n   = 1'b1;
    expLevel = 0;
    sb.delete();
  endtask

  task automatic test_basic();
    applyStimulus(1'b1, 32'h44332211, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    nChecks++;
    if (bus.r_data !== 8'h44) $display("[TB] FAIL basic last byte: got %h want 44", bus.r_data); else nPass++;
    nChecks++;
    if (bus.r_empty !== 1'b1) $display("[TB] FAIL basic r_empty: got %b want 1", bus.r_empty); else nPass++;
  endtask

  task automatic test_full();
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'hA0B0C0D0 + 32'(i * 32'h01010101), 1'b0);
    nChecks++;
    if (bus.w_full !== 1'b1) $display("[TB] FAIL full w_full: got %b want 1", bus.w_full); else nPass++;
    applyStimulus(1'b1, 32'hDEADBEEF, 1'b0);
    nChecks++;
    if (bus.level !== 5'd16) $display("[TB] FAIL full level after drop: got %0d want 16", bus.level); else nPass++;
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, 32'h0, 1'b1);
    nChecks++;
    if (bus.r_empty !== 1'b1) $display("[TB] FAIL full drain r_empty: got %b want 1", bus.r_empty); else nPass++;
  endtask

  task automatic test_simultaneous();
    applyReset();
    applyStimulus(1'b1, 32'h87654321, 1'b0);
    applyStimulus(1'b1, 32'hCAFEF00D, 1'b1);
    nChecks++;
    if (bus.ext_mem_w_addr !== 2'd2) $display("[TB] FAIL simul w_addr: got %0d want 2", bus.ext_mem_w_addr); else nPass++;
    nChecks++;
    if (bus.ext_mem_r_addr !== 4'd1) $display("[TB] FAIL simul r_addr: got %0d want 1", bus.ext_mem_r_addr); else nPass++;
    for (int i = 0; i < 7; i++) applyStimulus(1'b0, 32'h0, 1'b1);
  endtask

  task automatic test_empty_read();
    logic [7:0] prev;
    prev = lastRead;
    applyStimulus(1'b0, 32'h0, 1'b1);
    nChecks++;
    if (bus.r_data !== prev) $display("[TB] FAIL empty r_data held: got %h want %h", bus.r_data, prev); else nPass++;
    nChecks++;
    if (bus.r_empty !== 1'b1) $display("[TB] FAIL empty r_empty: got %b want 1", bus.r_empty); else nPass++;
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, {8'(i), 8'(i + 8'h40), 8'(i + 8'h80), 8'(i + 8'hC0)}, 1'b0);
      for (int j = 0; j < 4; j++) applyStimulus(1'b0, 32'h0, 1'b1);
    end
    applyStimulus(1'b1, 32'h13579BDF, 1'b0);
    applyStimulus(1'b1, 32'h2468ACE0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    @(negedge clk);
    #2 arst_n = 1'b0;
    #1;
    nChecks++;
    if (bus.level !== 5'd0) $display("[TB] FAIL midreset level: got %0d want 0", bus.level); else nPass++;
    nChecks++;
    if (bus.r_empty !== 1'b1) $display("[TB] FAIL midreset r_empty: got %b want 1", bus.r_empty); else nPass++;
    nChecks++;
    if (bus.w_full !== 1'b0) $display("[TB] FAIL midreset w_full: got %b want 0", bus.w_full); else nPass++;
    #1 arst_n = 1'b1;
    expLevel = 0;
    sb.delete();
    nChecks++;
    if ({bus.ext_mem_w_addr, bus.ext_mem_r_addr} !== 6'd0)
      $display("[TB] FAIL midreset addrs: got w=%0d r=%0d want 0/0", bus.ext_mem_w_addr, bus.ext_mem_r_addr);
    else nPass++;
    applyStimulus(1'b1, 32'h5A6B7C8D, 1'b0);
    for (int j = 0; j < 4; j++) applyStimulus(1'b0, 32'h0, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_simultaneous();
    test_empty_read();
    test_wrap();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
